// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with zero register, bypass and optional registered reads
//
// Purpose: CPU general-purpose register file. Decode reads rs/rt on ports 1/2,
// writeback writes rd, and a debug port exposes committed contents to trace logic.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset, clears every entry
//   we        write enable
//   waddr     write address
//   wdata     write data
//   raddr1    read port 1 address
//   rdata1    read port 1 data (combinational or registered per REG_READ)
//   raddr2    read port 2 address
//   rdata2    read port 2 data (combinational or registered per REG_READ)
//   dbg_addr  debug read address
//   dbg_data  debug read data, committed state only, never bypassed

module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Flop array so the asynchronous clear and combinational reads are legal.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic [DATA_W-1:0] v1;
  logic [DATA_W-1:0] v2;

  // A write is effective only out of reset and, with the zero register
  // enabled, never to entry 0. Gating with rst_n also keeps the bypass
  // path quiet while reset is held, so reads show the cleared state.
  assign wr_ok = we && rst_n && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Read value: zero register wins, then same-cycle write forwarding,
  // then stored contents. Later assignments take priority.
  always_comb begin
    v1 = mem[raddr1];
    if ((BYPASS != 0) && wr_ok && (waddr == raddr1)) begin
      v1 = wdata;
    end
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      v1 = '0;
    end
  end

  always_comb begin
    v2 = mem[raddr2];
    if ((BYPASS != 0) && wr_ok && (waddr == raddr2)) begin
      v2 = wdata;
    end
    if ((ZERO_REG != 0) && (raddr2 == '0)) begin
      v2 = '0;
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DATA_W-1:0] rd1_q;
      logic [DATA_W-1:0] rd2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= v1;
          rd2_q <= v2;
        end
      end

      assign rdata1 = rd1_q;
      assign rdata2 = rd2_q;
    end else begin : g_comb_read
      assign rdata1 = v1;
      assign rdata2 = v2;
    end
  endgenerate

  // Debug view is committed state only, so it bypasses nothing.
  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : mem[dbg_addr];

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - scoreboard bench for regfile_2r1w across four parameter sets
`timescale 1ns/1ps

module tb_regfile_2r1w;

  // Configurations: 0 comb+bypass, 1 registered+bypass, 2 narrow registered
  // no-bypass, 3 no zero register, no bypass, comb.
  localparam int DW [4] = '{32, 32, 16, 32};
  localparam int AW [4] = '{5, 5, 3, 5};
  localparam int ZR [4] = '{1, 1, 1, 0};
  localparam int BP [4] = '{1, 1, 0, 0};
  localparam int RR [4] = '{0, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [4:0]  dbg_addr = '0;
  logic        mid_chk = 1'b0;

  logic [31:0] a_r1, a_r2, a_dg;
  logic [31:0] b_r1, b_r2, b_dg;
  logic [15:0] c_r1, c_r2, c_dg;
  logic [31:0] d_r1, d_r2, d_dg;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .REG_READ(0)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(a_r1), .raddr2(raddr2), .rdata2(a_r2),
    .dbg_addr(dbg_addr), .dbg_data(a_dg));

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .REG_READ(1)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(b_r1), .raddr2(raddr2), .rdata2(b_r2),
    .dbg_addr(dbg_addr), .dbg_data(b_dg));

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0), .REG_READ(1)) u_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[2:0]), .wdata(wdata[15:0]),
    .raddr1(raddr1[2:0]), .rdata1(c_r1), .raddr2(raddr2[2:0]), .rdata2(c_r2),
    .dbg_addr(dbg_addr[2:0]), .dbg_data(c_dg));

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .REG_READ(0)) u_d (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(d_r1), .raddr2(raddr2), .rdata2(d_r2),
    .dbg_addr(dbg_addr), .dbg_data(d_dg));

  // Reference model: plain arrays per configuration plus the value each
  // registered port will show after the next edge.
  logic [31:0] mdl [4][32];
  logic [31:0] regv1 [4];
  logic [31:0] regv2 [4];

  typedef struct packed {
    logic [3:0][31:0] r1;
    logic [3:0][31:0] r2;
    logic [3:0][31:0] dg;
  } exp_t;

  exp_t exp_q [$];

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] dmask(int d);
    return (DW[d] == 32) ? 32'hFFFF_FFFF : ((32'h1 << DW[d]) - 32'h1);
  endfunction

  function automatic logic [4:0] amask(int d);
    return 5'(((32'h1 << AW[d]) - 32'h1));
  endfunction

  function automatic bit write_ok(int d);
    logic [4:0] wa;
    wa = waddr & amask(d);
    return rst_n && we && !(ZR[d] != 0 && wa == 5'd0);
  endfunction

  function automatic logic [31:0] read_val(int d, logic [4:0] addr);
    logic [4:0] a;
    a = addr & amask(d);
    if (ZR[d] != 0 && a == 5'd0) return 32'h0;
    if (BP[d] != 0 && write_ok(d) && ((waddr & amask(d)) == a)) return wdata & dmask(d);
    return mdl[d][a];
  endfunction

  function automatic logic [31:0] dbg_val(int d, logic [4:0] addr);
    logic [4:0] a;
    a = addr & amask(d);
    if (ZR[d] != 0 && a == 5'd0) return 32'h0;
    return mdl[d][a];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
      regv1[d] = 32'h0;
      regv2[d] = 32'h0;
    end
  endtask

  // Called right after a rising edge while the inputs still hold the
  // values the design sampled on that edge.
  task automatic model_edge();
    for (int d = 0; d < 4; d++) begin
      if (RR[d] != 0) begin
        regv1[d] = read_val(d, raddr1);
        regv2[d] = read_val(d, raddr2);
      end
      if (write_ok(d)) mdl[d][waddr & amask(d)] = wdata & dmask(d);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.r1[d] = (RR[d] != 0) ? regv1[d] : read_val(d, raddr1);
      e.r2[d] = (RR[d] != 0) ? regv2[d] : read_val(d, raddr2);
      e.dg[d] = dbg_val(d, dbg_addr);
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cfg%0d t=%0t: got %h want %h", nm, d, $time, act, expv);
    end
  endtask

  // Monitor: compares whenever a sample strobe occurs and an expectation is queued.
  initial begin
    exp_t e;
    logic [3:0][31:0] act1, act2, actd;
    forever begin
      @(negedge clk or posedge mid_chk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act1 = {d_r1, {16'h0, c_r1}, b_r1, a_r1};
        act2 = {d_r2, {16'h0, c_r2}, b_r2, a_r2};
        actd = {d_dg, {16'h0, c_dg}, b_dg, a_dg};
        for (int d = 0; d < 4; d++) begin
          check("rdata1", d, act1[d], e.r1[d]);
          check("rdata2", d, act2[d], e.r2[d]);
          check("dbg_data", d, actd[d], e.dg[d]);
        end
      end
    end
  end

  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    @(posedge clk);
    model_edge();
    #1;
    we = w;
    waddr = wa;
    wdata = wd;
    raddr1 = a1;
    raddr2 = a2;
    dbg_addr = ad;
    push_exp();
  endtask

  // Mid-cycle reset pulse of 3 ns with a write request held during reset.
  task automatic pulse_reset();
    #5;
    rst_n = 1'b0;
    we = 1'b1;
    waddr = 5'd5;
    wdata = 32'h1111_1111;
    #1;
    model_clear();
    push_exp();
    mid_chk = 1'b1;
    #1;
    mid_chk = 1'b0;
    we = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    #2;
    push_exp();
    mid_chk = 1'b1;
    #1;
    mid_chk = 1'b0;
    #9;
    rst_n = 1'b1;

    // Reset behaviour
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    pulse_reset();
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);

    // Zero register
    cycle(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Dual read, identical addresses
    cycle(1'b1, 5'd3, 32'hAAAA_5555, 5'd0, 5'd0, 5'd0);
    cycle(1'b1, 5'd7, 32'h0F0F_0F0F, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 5'd3);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);

    // Bypass versus committed view
    cycle(1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 5'd9);
    cycle(1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

    // Registered read latency, back-to-back addresses
    cycle(1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd4, 5'd4);
    cycle(1'b1, 5'd5, 32'h5555_0005, 5'd1, 5'd5, 5'd5);
    cycle(1'b1, 5'd6, 32'h6666_0006, 5'd1, 5'd6, 5'd6);
    cycle(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 5'd6);
    cycle(1'b0, 5'd0, 32'h0, 5'd6, 5'd4, 5'd4);

    // Sweep
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      cycle(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 0, 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
